// File: rtl/tsense_monitor.sv
// Temperature monitor behind the LM07 SPI reader: captures each reading on CS rise,
// keeps a 4-sample moving average, min/max, a hysteretic over-temp alarm and a stale flag.
module tsense_monitor #(
  parameter logic [7:0] T_HIGH  = 8'd40,
  parameter logic [7:0] T_LOW   = 8'd35,
  parameter int         TIMEOUT = 64
) (
  input  logic       SYSCLK,
  input  logic       RSTN,
  input  logic       CS_IN,
  input  logic [7:0] TEMP_IN,
  input  logic       CLR_MINMAX,
  output logic [7:0] AVG_OUT,
  output logic [7:0] TMIN,
  output logic [7:0] TMAX,
  output logic       ALARM,
  output logic       STALE,
  output logic       VALID,
  output logic [7:0] NSAMP
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic       cs_q;
  logic       first_q, first_d;
  logic       mm_init_q, mm_init_d;
  logic [7:0] w0_q, w1_q, w2_q, w3_q;
  logic [7:0] w0_d, w1_d, w2_d, w3_d;
  logic [9:0] sum_q, sum_d;
  logic       v1_q;
  logic [7:0] avg_q, avg_d;
  logic       alarm_q, alarm_d;
  logic       valid_q;
  logic [7:0] tmin_q, tmin_d;
  logic [7:0] tmax_q, tmax_d;
  logic [7:0] nsamp_q, nsamp_d;
  logic [7:0] stale_cnt_q, stale_cnt_d;
  logic       cap;
  logic [7:0] avg_new;

  assign cap     = CS_IN & ~cs_q;
  assign avg_new = sum_q[9:2];

  always_comb begin
    first_d     = first_q;
    mm_init_d   = mm_init_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    w3_d        = w3_q;
    sum_d       = sum_q;
    nsamp_d     = nsamp_q;
    tmin_d      = tmin_q;
    tmax_d      = tmax_q;
    avg_d       = avg_q;
    alarm_d     = alarm_q;

    if (cap) begin
      // First capture preloads the whole window so the average has no warm-up bias.
      if (first_q) begin
        w0_d    = TEMP_IN;
        w1_d    = TEMP_IN;
        w2_d    = TEMP_IN;
        w3_d    = TEMP_IN;
        first_d = 1'b0;
      end else begin
        w0_d = TEMP_IN;
        w1_d = w0_q;
        w2_d = w1_q;
        w3_d = w2_q;
      end
      sum_d   = 10'(w0_d) + 10'(w1_d) + 10'(w2_d) + 10'(w3_d);
      nsamp_d = (nsamp_q == 8'hFF) ? nsamp_q : nsamp_q + 8'd1;
      if (mm_init_q || CLR_MINMAX) begin
        tmin_d    = TEMP_IN;
        tmax_d    = TEMP_IN;
        mm_init_d = 1'b0;
      end else begin
        tmin_d = (TEMP_IN < tmin_q) ? TEMP_IN : tmin_q;
        tmax_d = (TEMP_IN > tmax_q) ? TEMP_IN : tmax_q;
      end
    end else if (CLR_MINMAX) begin
      mm_init_d = 1'b1;
    end

    if (v1_q) begin
      avg_d = avg_new;
      if (avg_new >= T_HIGH) begin
        alarm_d = 1'b1;
      end else if (avg_new <= T_LOW) begin
        alarm_d = 1'b0;
      end
    end

    if (cap) begin
      stale_cnt_d = 8'd0;
    end else if (stale_cnt_q == TO_CNT) begin
      stale_cnt_d = stale_cnt_q;
    end else begin
      stale_cnt_d = stale_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      cs_q        <= 1'b1;
      first_q     <= 1'b1;
      mm_init_q   <= 1'b1;
      w0_q        <= 8'd0;
      w1_q        <= 8'd0;
      w2_q        <= 8'd0;
      w3_q        <= 8'd0;
      sum_q       <= 10'd0;
      v1_q        <= 1'b0;
      avg_q       <= 8'd0;
      alarm_q     <= 1'b0;
      valid_q     <= 1'b0;
      tmin_q      <= 8'd0;
      tmax_q      <= 8'd0;
      nsamp_q     <= 8'd0;
      stale_cnt_q <= 8'd0;
    end else begin
      cs_q        <= CS_IN;
      first_q     <= first_d;
      mm_init_q   <= mm_init_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      w3_q        <= w3_d;
      sum_q       <= sum_d;
      v1_q        <= cap;
      avg_q       <= avg_d;
      alarm_q     <= alarm_d;
      valid_q     <= v1_q;
      tmin_q      <= tmin_d;
      tmax_q      <= tmax_d;
      nsamp_q     <= nsamp_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign AVG_OUT = avg_q;
  assign TMIN    = tmin_q;
  assign TMAX    = tmax_q;
  assign ALARM   = alarm_q;
  assign STALE   = (stale_cnt_q == TO_CNT);
  assign VALID   = valid_q;
  assign NSAMP   = nsamp_q;

endmodule
